// File: rtl/cnt_snapshot_tx.sv
// Captures two 64-bit counters on request and streams them as an 18-byte frame:
// header, Cnt0 LSB-first, Cnt1 LSB-first, XOR checksum of the 16 counter bytes.
module cnt_snapshot_tx #(
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [63:0] Cnt0,
  input  logic [63:0] Cnt1,
  input  logic        Req,
  input  logic        TxReady,
  output logic [7:0]  TxData,
  output logic        TxValid,
  output logic        TxLast,
  output logic        Busy,
  output logic        Overrun
);

  typedef enum logic [2:0] {StIdle, StHdr, StC0, StC1, StCsum} state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [63:0] snap0_q;
  logic [63:0] snap1_q;
  logic [7:0]  data_q;
  logic        overrun_q;

  logic        xfer;
  logic [2:0]  idx_inc;
  logic [7:0]  c0_byte_nxt;
  logic [7:0]  c1_byte_nxt;
  logic [7:0]  csum;

  assign xfer        = TxValid & TxReady;
  assign idx_inc     = idx_q + 3'd1;
  assign c0_byte_nxt = snap0_q[{idx_inc, 3'b000} +: 8];
  assign c1_byte_nxt = snap1_q[{idx_inc, 3'b000} +: 8];

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 8; i++) begin
      csum = csum ^ snap0_q[i*8 +: 8] ^ snap1_q[i*8 +: 8];
    end
  end

  // data_q always holds the byte for the current state, so it is preloaded on each transfer.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      idx_q     <= 3'd0;
      snap0_q   <= 64'd0;
      snap1_q   <= 64'd0;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= Req && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (Req) begin
            snap0_q <= Cnt0;
            snap1_q <= Cnt1;
            data_q  <= HDR;
            idx_q   <= 3'd0;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          if (xfer) begin
            data_q  <= snap0_q[7:0];
            state_q <= StC0;
          end
        end
        StC0: begin
          if (xfer) begin
            idx_q <= idx_inc;
            if (idx_q == 3'd7) begin
              data_q  <= snap1_q[7:0];
              state_q <= StC1;
            end else begin
              data_q <= c0_byte_nxt;
            end
          end
        end
        StC1: begin
          if (xfer) begin
            idx_q <= idx_inc;
            if (idx_q == 3'd7) begin
              data_q  <= csum;
              state_q <= StCsum;
            end else begin
              data_q <= c1_byte_nxt;
            end
          end
        end
        StCsum: begin
          if (xfer) begin
            data_q  <= 8'h00;
            state_q <= StIdle;
          end
        end
        default: begin
          data_q  <= 8'h00;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign TxData  = data_q;
  assign TxValid = (state_q != StIdle);
  assign Busy    = (state_q != StIdle);
  assign TxLast  = (state_q == StCsum);
  assign Overrun = overrun_q;

endmodule

// File: doc/cnt_snapshot_tx.md
CNT_SNAPSHOT_TX -- requirements
Module: cnt_snapshot_tx

Parameters
REQ-001 SHALL have parameter HDR, default 8'hA5, meaning the frame header byte.

Interface
REQ-002 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Cnt0, input, 64, counter value 0.
REQ-005 SHALL have port Cnt1, input, 64, counter value 1.
REQ-006 SHALL have port Req, input, 1, snapshot request, sampled on the rising edge of Clk.
REQ-007 SHALL have port TxReady, input, 1, downstream ready.
REQ-008 SHALL have port TxData, output, 8, frame byte.
REQ-009 SHALL have port TxValid, output, 1, TxData valid.
REQ-010 SHALL have port TxLast, output, 1, marks the final byte of a frame.
REQ-011 SHALL have port Busy, output, 1, high while a frame is in progress.
REQ-012 SHALL have port Overrun, output, 1, one-cycle pulse when a Req is dropped.

Function
REQ-013 SHALL implement states IDLE, HDR, C0, C1 and CSUM, with Busy = (state != IDLE).
REQ-014 SHALL, on a rising edge with state IDLE and Req=1, capture Cnt0 and Cnt1 into internal 64-bit snapshot registers and enter HDR.
REQ-015 SHALL assert TxValid with TxData=HDR in the cycle after Req is accepted, giving 1-cycle request-to-valid latency.
REQ-016 SHALL complete a byte transfer only on a rising edge where TxValid=1 and TxReady=1.
REQ-017 SHALL hold TxData, TxValid and TxLast stable while TxValid=1 and TxReady=0.
REQ-018 SHALL emit an 18-byte frame: HDR; snapshot Cnt0 bytes 0..7, LSB first; snapshot Cnt1 bytes 0..7, LSB first; checksum.
REQ-019 SHALL compute the checksum as the XOR of the 16 counter bytes, excluding HDR.
REQ-020 SHALL use a 3-bit byte index in C0 and C1, advancing on each transfer.
REQ-021 SHALL leave C0 for C1, and C1 for CSUM, on the transfer of byte index 7, with the index wrapping to 0.
REQ-022 SHALL assert TxLast only in CSUM.
REQ-023 SHALL return to IDLE on the CSUM transfer.
REQ-024 SHALL keep TxValid=1 continuously from HDR through CSUM, with no bubbles.
REQ-025 SHALL make the frame take exactly 18 cycles when TxReady is held at 1.
REQ-026 SHALL send frame bytes from the snapshot only; changes on Cnt0/Cnt1 after capture SHALL NOT affect the frame.
REQ-027 SHALL drop Req=1 sampled in any non-IDLE state, including the CSUM transfer cycle, and pulse Overrun for exactly one cycle.
REQ-028 SHALL require at least one IDLE cycle between frames; Req in the first IDLE cycle after a frame SHALL be accepted.
REQ-029 SHALL drive TxData=8'h00 whenever TxValid=0.

Reset
REQ-030 SHALL, while Reset=0, immediately force state IDLE and TxValid=0, TxLast=0, Busy=0, Overrun=0, TxData=8'h00, byte index 0, snapshots 0, independent of Clk.
REQ-031 SHALL abandon a frame interrupted by reset mid-frame and SHALL NOT resume it.
REQ-032 SHALL ignore Req until the first rising edge of Clk with Reset=1.

Verification
REQ-033 SHALL cover basic frame: Cnt0=64'h3, Cnt1=64'h5, Req pulse, TxReady=1 -> A5,03,00x7,05,00x7,06; TxLast on byte 18 only; Busy high 18 cycles.
REQ-034 SHALL cover byte order: Cnt0=64'h0807060504030201, Cnt1=0 -> bytes 01..08 then 8 zeros, checksum 08.
REQ-035 SHALL cover backpressure: TxReady toggling 1,0,0,1 on every transfer -> byte sequence identical to REQ-033, with TxData stable through every stall.
REQ-036 SHALL cover snapshot isolation: Cnt0 incremented every cycle after Req -> frame carries the value present at the accepting edge.
REQ-037 SHALL cover overrun: Req at byte 5 and at the CSUM transfer -> two one-cycle Overrun pulses, frame unaffected, next-cycle IDLE Req accepted.
REQ-038 SHALL cover reset mid-frame: Reset=0 at byte 9 -> TxValid=0 without waiting for a Clk edge; after release, a new Req produces a fresh full frame starting with A5.
